// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the imem address and loads the IF/ID register.
// It honours hazard-unit stalls and branch redirects, and counts stall and flush cycles.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCWrite,
  input  logic        IF_ID_Write,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic [31:0] pc_if,
  output logic [31:0] pc_id,
  output logic [31:0] pc_plus4_id,
  output logic [31:0] instr_id,
  output logic        valid_id,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
);

  logic [31:0] pc_q;
  logic [31:0] pc_next;
  logic [31:0] pc_inc;
  logic [31:0] pc_id_q;
  logic [31:0] pc_plus4_id_q;
  logic [31:0] instr_id_q;
  logic        valid_id_q;
  logic [31:0] stall_count_q;
  logic [31:0] flush_count_q;
  logic        stall_event;

  assign pc_inc = pc_q + 32'd4;

  // A redirect comes from an older instruction than anything stalled, so it wins.
  always_comb begin
    pc_next = pc_q;
    if (branch_taken) begin
      pc_next = {branch_target[31:2], 2'b00};
    end else if (PCWrite) begin
      pc_next = pc_inc;
    end
  end

  assign stall_event = !branch_taken && (!PCWrite || !IF_ID_Write);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_id_q    <= NOP_INSTR;
      pc_id_q       <= 32'd0;
      pc_plus4_id_q <= 32'd0;
      valid_id_q    <= 1'b0;
    end else if (branch_taken) begin
      instr_id_q    <= NOP_INSTR;
      pc_id_q       <= 32'd0;
      pc_plus4_id_q <= 32'd0;
      valid_id_q    <= 1'b0;
    end else if (IF_ID_Write) begin
      instr_id_q    <= imem_rdata;
      pc_id_q       <= pc_q;
      pc_plus4_id_q <= pc_inc;
      valid_id_q    <= 1'b1;
    end
  end

  // Performance counters wrap silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count_q <= 32'd0;
      flush_count_q <= 32'd0;
    end else begin
      if (stall_event) begin
        stall_count_q <= stall_count_q + 32'd1;
      end
      if (branch_taken) begin
        flush_count_q <= flush_count_q + 32'd1;
      end
    end
  end

  assign pc_if       = pc_q;
  assign imem_addr   = pc_q;
  assign pc_id       = pc_id_q;
  assign pc_plus4_id = pc_plus4_id_q;
  assign instr_id    = instr_id_q;
  assign valid_id    = valid_id_q;
  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random stall/branch traffic
// against a cycle-level reference model of the fetch stage.
module tb_fetch_stage;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] IMEM_KEY = 32'hA5A5_0000;

  logic        clk;
  logic        rst;
  logic        PCWrite;
  logic        IF_ID_Write;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_rdata;
  logic [31:0] imem_addr;
  logic [31:0] pc_if;
  logic [31:0] pc_id;
  logic [31:0] pc_plus4_id;
  logic [31:0] instr_id;
  logic        valid_id;
  logic [31:0] stall_count;
  logic [31:0] flush_count;

  int n_vec;
  int n_err;

  // reference model state
  logic [31:0] m_pc, m_pc_id, m_pc4_id, m_instr, m_stalls, m_flushes;
  logic        m_valid;

  fetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .PCWrite      (PCWrite),
    .IF_ID_Write  (IF_ID_Write),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_rdata   (imem_rdata),
    .imem_addr    (imem_addr),
    .pc_if        (pc_if),
    .pc_id        (pc_id),
    .pc_plus4_id  (pc_plus4_id),
    .instr_id     (instr_id),
    .valid_id     (valid_id),
    .stall_count  (stall_count),
    .flush_count  (flush_count)
  );

  // instruction memory: word content is its address xor a key
  assign imem_rdata = imem_addr ^ IMEM_KEY;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return addr ^ IMEM_KEY;
  endfunction

  task automatic model_reset();
    m_pc      = 32'h0;
    m_pc_id   = 32'h0;
    m_pc4_id  = 32'h0;
    m_instr   = NOP;
    m_valid   = 1'b0;
    m_stalls  = 32'h0;
    m_flushes = 32'h0;
  endtask

  // one clock edge of the reference: the fetched word goes to decode unless
  // squashed by a redirect or held by a stall
  task automatic model_edge(input logic br, input logic [31:0] tgt,
                            input logic pcw, input logic ifw);
    logic [31:0] fetched_pc;
    fetched_pc = m_pc;
    if (br) begin
      m_flushes++;
      m_instr  = NOP;
      m_valid  = 1'b0;
      m_pc_id  = 32'h0;
      m_pc4_id = 32'h0;
      m_pc     = tgt & ~32'h3;
    end else begin
      if (!pcw || !ifw) m_stalls++;
      if (ifw) begin
        m_instr  = mem_word(fetched_pc);
        m_valid  = 1'b1;
        m_pc_id  = fetched_pc;
        m_pc4_id = fetched_pc + 32'd4;
      end
      if (pcw) m_pc = fetched_pc + 32'd4;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc_if"},       pc_if,         m_pc);
    check({tag, ".imem_addr"},   imem_addr,     m_pc);
    check({tag, ".pc_id"},       pc_id,         m_pc_id);
    check({tag, ".pc_plus4_id"}, pc_plus4_id,   m_pc4_id);
    check({tag, ".instr_id"},    instr_id,      m_instr);
    check({tag, ".valid_id"},    {31'h0, valid_id}, {31'h0, m_valid});
    check({tag, ".stall_count"}, stall_count,   m_stalls);
    check({tag, ".flush_count"}, flush_count,   m_flushes);
  endtask

  // driver: apply inputs, take one edge, compare just after it
  task automatic cycle(input string tag, input logic br, input logic [31:0] tgt,
                       input logic pcw, input logic ifw);
    branch_taken  = br;
    branch_target = tgt;
    PCWrite       = pcw;
    IF_ID_Write   = ifw;
    @(posedge clk);
    model_edge(br, tgt, pcw, ifw);
    #1;
    check_all(tag);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst           = 1'b1;
    PCWrite       = 1'b1;
    IF_ID_Write   = 1'b1;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    model_reset();
    #12;
    check_all("reset");
    rst = 1'b0;

    // free run
    for (int i = 0; i < 3; i++) cycle("run", 1'b0, 32'h0, 1'b1, 1'b1);
    check("run3.pc_if", pc_if, 32'hC);
    check("run3.pc_id", pc_id, 32'h8);
    check("run3.instr_id", instr_id, 32'hA5A5_0008);
    check("run3.valid", {31'h0, valid_id}, 32'h1);
    cycle("run", 1'b0, 32'h0, 1'b1, 1'b1);

    // two-cycle stall at pc 0x10
    cycle("stall", 1'b0, 32'h0, 1'b0, 1'b0);
    cycle("stall", 1'b0, 32'h0, 1'b0, 1'b0);
    check("stall.pc_if", pc_if, 32'h10);
    check("stall.pc_id", pc_id, 32'hC);
    check("stall.count", stall_count, 32'd2);
    cycle("release", 1'b0, 32'h0, 1'b1, 1'b1);
    check("release.pc_id", pc_id, 32'h10);

    // mismatched stall controls
    cycle("pconly", 1'b0, 32'h0, 1'b1, 1'b0);
    cycle("ifonly", 1'b0, 32'h0, 1'b0, 1'b1);
    while (m_pc != 32'h20) cycle("run", 1'b0, 32'h0, 1'b1, 1'b1);

    // branch with unaligned target
    cycle("branch", 1'b1, 32'h103, 1'b1, 1'b1);
    check("branch.pc_if", pc_if, 32'h100);
    check("branch.instr", instr_id, NOP);
    check("branch.valid", {31'h0, valid_id}, 32'h0);
    cycle("tgt", 1'b0, 32'h0, 1'b1, 1'b1);
    check("tgt.pc_id", pc_id, 32'h100);
    check("tgt.valid", {31'h0, valid_id}, 32'h1);

    // branch wins over stall
    cycle("brstall", 1'b1, 32'h200, 1'b0, 1'b0);
    check("brstall.pc_if", pc_if, 32'h200);
    cycle("run", 1'b0, 32'h0, 1'b1, 1'b1);

    // PC wrap
    cycle("towrap", 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1);
    check("towrap.pc_if", pc_if, 32'hFFFF_FFFC);
    cycle("wrap", 1'b0, 32'h0, 1'b1, 1'b1);
    check("wrap.pc_if", pc_if, 32'h0);
    check("wrap.pc_plus4_id", pc_plus4_id, 32'h0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic br, pcw, ifw;
      br  = ($urandom_range(0, 7) == 0);
      pcw = ($urandom_range(0, 3) != 0);
      ifw = ($urandom_range(0, 3) != 0);
      cycle("rand", br, $urandom, pcw, ifw);
    end

    // asynchronous reset in the middle of a stall
    cycle("prestall", 1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    #3;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cycle("recover", 1'b0, 32'h0, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
